pc_fetch_unit: RTL and testbench
================================

// Module: pc_fetch_unit
// PURPOSE
//   Program-counter register and instruction-fetch sequencer for the LEGv8 core.
//   - Holds CurrentPC and loads NextPC (from the next-PC adder/branch mux) only when the core retires the held instruction.
//   - Fetches the word at CurrentPC from instruction memory over a req/ack handshake with variable latency.
//   - Presents the instruction to decode with a valid flag.
// PARAMETERS
//   RESET_PC  64'h0  PC loaded on reset; must be word-aligned (RESET_PC[1:0]==0).
//   INST_W    32     Instruction word width.
// PORTS
//   CLK          in   1       Clock; all state updates on rising edge.
//   Reset        in   1       Synchronous, active-high reset.
//   NextPC       in   64      Next PC from the next-PC logic; sampled only on an accepted Advance.
//   Advance      in   1       Core retires the held instruction; acted on only when InstValid=1.
//   CurrentPC    out  64      Registered PC of the instruction being fetched or held.
//   imem_req     out  1       Fetch request to instruction memory.
//   imem_addr    out  64      Fetch address; equals CurrentPC.
//   imem_ack     in   1       Memory returns data this cycle; sampled only in state REQ.
//   imem_rdata   in   INST_W  Instruction data; valid when imem_ack=1.
//   Instruction  out  INST_W  Registered instruction for decode.
//   InstValid    out  1       Instruction holds the word at CurrentPC.
//   Fault        out  1       Sticky misaligned-PC fault.
// BEHAVIOUR
//   Reset (sync, any state, including mid-fetch):
//   - CurrentPC=RESET_PC, Instruction=0, InstValid=0, Fault=0, state=REQ.
//   - imem_req is forced 0 while Reset=1. An outstanding fetch is abandoned.
//   States: REQ, HOLD, FAULT. imem_req = (state==REQ) & ~Reset.
//   REQ:
//   - imem_addr=CurrentPC, held stable until ack.
//   - On imem_ack: Instruction<=imem_rdata, InstValid<=1, go to HOLD.
//   - Ack in the same cycle as req is legal. Minimum latency is req at cycle t -> InstValid=1 at t+1.
//   HOLD:
//   - imem_req=0; Instruction and InstValid are held.
//   - Advance with NextPC[1:0]==0: CurrentPC<=NextPC, InstValid<=0, go to REQ. The new request issues the next cycle.
//   - Advance with NextPC[1:0]!=0: Fault<=1, InstValid<=0, CurrentPC unchanged, go to FAULT.
//   FAULT:
//   - imem_req=0, InstValid=0, Fault=1.
//   - Only Reset exits FAULT; Advance and imem_ack are ignored.
//   Boundaries:
//   - Advance while InstValid=0 is ignored; NextPC is not sampled.
//   - imem_ack outside REQ is ignored.
//   - NextPC==CurrentPC (self-branch) refetches the same address.
//   - PC arithmetic is done upstream; no wrap or overflow checks here. 64'hFFFF_FFFF_FFFF_FFFC is a legal PC.
//   - Reset and Advance in the same cycle: Reset wins.
//   - Reset and imem_ack in the same cycle: the data is discarded.
// CONFIGURATION
//   FETCH_PERF_EN defined:
//   - Adds output RetireCount (32): count of accepted Advances.
//   - Adds output StallCount (32): count of cycles with state==REQ && !imem_ack.
//   - Both counters reset to 0, wrap modulo 2^32, and freeze in FAULT.
//   FETCH_PERF_EN undefined: both ports and their logic are absent; all other behaviour is identical.
// TESTING
//   1. Reset held 2 cycles, RESET_PC=0 -> during reset CurrentPC=0, InstValid=0, imem_req=0; first cycle after release imem_req=1, imem_addr=0.
//   2. Same-cycle ack, imem_rdata=32'h8B020020 -> next cycle InstValid=1, Instruction=32'h8B020020; Advance with NextPC=4 -> CurrentPC=4, InstValid=0, imem_req=1 next cycle.
//   3. Ack delayed 3 cycles, Advance pulsed during the wait -> imem_addr stable at 4 for 4 cycles; Advance ignored; CurrentPC stays 4.
//   4. Taken CBZ: NextPC=64'h40 on Advance -> imem_addr=64'h40; Reset asserted mid-fetch -> CurrentPC=0, imem_req=0, InstValid=0.
//   5. NextPC=64'h42 on Advance -> Fault=1, imem_req stays 0 for 10 cycles despite Advance/ack; Reset -> Fault=0, fetch restarts at 0.
//   6. FETCH_PERF_EN, 5 Advances, 2-cycle ack latency each -> RetireCount=5, StallCount=5; counters reset at Reset.

Source files
------------

// File: rtl/pc_fetch_unit.sv
// LEGv8 program-counter register and instruction-fetch sequencer (REQ/HOLD/FAULT).
// Optional counters RetireCount/StallCount are compiled in when FETCH_PERF_EN is defined.
module pc_fetch_unit #(
  parameter logic [63:0] RESET_PC = 64'h0,
  parameter int          INST_W   = 32
) (
  input  logic              CLK,
  input  logic              Reset,
  input  logic [63:0]       NextPC,
  input  logic              Advance,
  output logic [63:0]       CurrentPC,
  output logic              imem_req,
  output logic [63:0]       imem_addr,
  input  logic              imem_ack,
  input  logic [INST_W-1:0] imem_rdata,
  output logic [INST_W-1:0] Instruction,
  output logic              InstValid,
  output logic              Fault
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]       RetireCount,
  output logic [31:0]       StallCount
`endif
);

  typedef enum logic [1:0] {
    ST_REQ   = 2'd0,
    ST_HOLD  = 2'd1,
    ST_FAULT = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [63:0]         pc_q, pc_d;
  logic [INST_W-1:0]   inst_q, inst_d;
  logic                valid_q, valid_d;
  logic                fault_q, fault_d;
  logic                imem_req_s;
  logic                adv_ok_s;
  logic                aligned_s;

  assign adv_ok_s  = (state_q == ST_HOLD) && Advance && valid_q;
  assign aligned_s = (NextPC[1:0] == 2'b00);

  // State register
  always_ff @(posedge CLK) begin
    if (Reset) begin
      state_q <= ST_REQ;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_REQ: begin
        if (imem_ack) state_d = ST_HOLD;
        else          state_d = ST_REQ;
      end
      ST_HOLD: begin
        if (adv_ok_s) begin
          if (aligned_s) state_d = ST_REQ;
          else           state_d = ST_FAULT;
        end else begin
          state_d = ST_HOLD;
        end
      end
      ST_FAULT: state_d = ST_FAULT;
      default:  state_d = ST_REQ;
    endcase
  end

  // Output decode; the request drops combinationally while Reset is high
  always_comb begin
    imem_req_s = 1'b0;
    case (state_q)
      ST_REQ:   imem_req_s = ~Reset;
      ST_HOLD:  imem_req_s = 1'b0;
      ST_FAULT: imem_req_s = 1'b0;
      default:  imem_req_s = 1'b0;
    endcase
  end

  // PC / instruction / flag update
  always_comb begin
    pc_d    = pc_q;
    inst_d  = inst_q;
    valid_d = valid_q;
    fault_d = fault_q;
    case (state_q)
      ST_REQ: begin
        if (imem_ack) begin
          inst_d  = imem_rdata;
          valid_d = 1'b1;
        end else begin
          valid_d = 1'b0;
        end
      end
      ST_HOLD: begin
        if (adv_ok_s) begin
          valid_d = 1'b0;
          if (aligned_s) pc_d    = NextPC;
          else           fault_d = 1'b1;
        end else begin
          valid_d = valid_q;
        end
      end
      ST_FAULT: begin
        valid_d = 1'b0;
        fault_d = 1'b1;
      end
      default: begin
        valid_d = 1'b0;
      end
    endcase
  end

  // Datapath registers
  always_ff @(posedge CLK) begin
    if (Reset) begin
      pc_q    <= RESET_PC;
      inst_q  <= {INST_W{1'b0}};
      valid_q <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      inst_q  <= inst_d;
      valid_q <= valid_d;
      fault_q <= fault_d;
    end
  end

  assign CurrentPC   = pc_q;
  assign imem_addr   = pc_q;
  assign imem_req    = imem_req_s;
  assign Instruction = inst_q;
  assign InstValid   = valid_q;
  assign Fault       = fault_q;

`ifdef FETCH_PERF_EN
  logic [31:0] retire_cnt_q, retire_cnt_d;
  logic [31:0] stall_cnt_q, stall_cnt_d;

  // Counters only move in REQ/HOLD, so they freeze in FAULT
  always_comb begin
    retire_cnt_d = retire_cnt_q;
    stall_cnt_d  = stall_cnt_q;
    if (adv_ok_s) retire_cnt_d = retire_cnt_q + 32'd1;
    else          retire_cnt_d = retire_cnt_q;
    if ((state_q == ST_REQ) && !imem_ack) stall_cnt_d = stall_cnt_q + 32'd1;
    else                                  stall_cnt_d = stall_cnt_q;
  end

  // Counter registers
  always_ff @(posedge CLK) begin
    if (Reset) begin
      retire_cnt_q <= 32'd0;
      stall_cnt_q  <= 32'd0;
    end else begin
      retire_cnt_q <= retire_cnt_d;
      stall_cnt_q  <= stall_cnt_d;
    end
  end

  assign RetireCount = retire_cnt_q;
  assign StallCount  = stall_cnt_q;
`endif

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed bench for pc_fetch_unit: fetch stimulus pushes expected {PC, word} into a
// scoreboard queue that a negedge monitor pops whenever InstValid rises.
module tb_pc_fetch_unit;

  logic        CLK = 1'b0;
  logic        Reset;
  logic [63:0] NextPC;
  logic        Advance;
  logic [63:0] CurrentPC;
  logic        imem_req;
  logic [63:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] Instruction;
  logic        InstValid;
  logic        Fault;
`ifdef FETCH_PERF_EN
  logic [31:0] RetireCount;
  logic [31:0] StallCount;
`endif

  int n_vec = 0;
  int n_err = 0;

  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] inst;
  } exp_t;
  exp_t exp_q[$];

  pc_fetch_unit #(.RESET_PC(64'h0), .INST_W(32)) dut (
    .CLK(CLK), .Reset(Reset), .NextPC(NextPC), .Advance(Advance),
    .CurrentPC(CurrentPC), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata), .Instruction(Instruction),
    .InstValid(InstValid), .Fault(Fault)
`ifdef FETCH_PERF_EN
    , .RetireCount(RetireCount), .StallCount(StallCount)
`endif
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: one pop per completed fetch
  logic valid_prev = 1'b0;
  always @(negedge CLK) begin
    exp_t e;
    if (InstValid === 1'b1 && valid_prev !== 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_instvalid", 64'd1, 64'd0);
      end else begin
        e = exp_q.pop_front();
        chk("sb_pc", CurrentPC, e.pc);
        chk("sb_inst", {32'd0, Instruction}, {32'd0, e.inst});
      end
    end
    valid_prev = InstValid;
  end

  // Serve one fetch at pc with lat wait cycles; optionally pulse Advance while waiting
  task automatic fetch(input int lat, input logic [63:0] pc, input logic [31:0] data,
                       input logic adv_during);
    exp_q.push_back('{pc: pc, inst: data});
    for (int i = 0; i < lat; i++) begin
      #1;
      chk("wait_req", {63'd0, imem_req}, 64'd1);
      chk("wait_addr", imem_addr, pc);
      imem_ack = 1'b0;
      Advance  = adv_during && (i == 0);
      NextPC   = 64'h100;
      @(negedge CLK);
      Advance  = 1'b0;
    end
    #1;
    chk("ack_req", {63'd0, imem_req}, 64'd1);
    chk("ack_addr", imem_addr, pc);
    imem_ack   = 1'b1;
    imem_rdata = data;
    @(negedge CLK);
    imem_ack   = 1'b0;
    imem_rdata = 32'h0;
    #1;
    chk("hold_valid", {63'd0, InstValid}, 64'd1);
    chk("hold_req", {63'd0, imem_req}, 64'd0);
  endtask

  // Retire with an aligned next PC
  task automatic adv(input logic [63:0] npc);
    Advance = 1'b1;
    NextPC  = npc;
    @(negedge CLK);
    Advance = 1'b0;
    #1;
    chk("adv_pc", CurrentPC, npc);
    chk("adv_valid", {63'd0, InstValid}, 64'd0);
    chk("adv_req", {63'd0, imem_req}, 64'd1);
  endtask

  initial begin
    Reset = 1'b1; NextPC = 64'h0; Advance = 1'b0; imem_ack = 1'b0; imem_rdata = 32'h0;
    // 1: reset held two cycles
    for (int i = 0; i < 2; i++) begin
      @(negedge CLK);
      chk("rst_pc", CurrentPC, 64'h0);
      chk("rst_valid", {63'd0, InstValid}, 64'd0);
      chk("rst_req", {63'd0, imem_req}, 64'd0);
      chk("rst_fault", {63'd0, Fault}, 64'd0);
    end
    Reset = 1'b0;
    // 2: same-cycle ack, then advance to 4
    fetch(0, 64'h0, 32'h8B020020, 1'b0);
    adv(64'h4);
    // 3: three-cycle ack latency with an Advance pulse that must be ignored
    fetch(3, 64'h4, 32'hF9400041, 1'b1);
    chk("ignored_adv_pc", CurrentPC, 64'h4);
    // 4: taken branch to 0x40, reset mid-fetch with a coincident ack
    adv(64'h40);
    #1;
    chk("br_addr", imem_addr, 64'h40);
    @(negedge CLK);
    Reset = 1'b1; imem_ack = 1'b1; imem_rdata = 32'hDEADBEEF;
    @(negedge CLK);
    imem_ack = 1'b0;
    #1;
    chk("midrst_pc", CurrentPC, 64'h0);
    chk("midrst_req", {63'd0, imem_req}, 64'd0);
    chk("midrst_valid", {63'd0, InstValid}, 64'd0);
    Reset = 1'b0;
    fetch(1, 64'h0, 32'h91000421, 1'b0);
    // top-of-space PC, then self-branch refetch
    adv(64'hFFFF_FFFF_FFFF_FFFC);
    fetch(2, 64'hFFFF_FFFF_FFFF_FFFC, 32'h14000000, 1'b0);
    adv(64'hFFFF_FFFF_FFFF_FFFC);
    fetch(0, 64'hFFFF_FFFF_FFFF_FFFC, 32'h14000001, 1'b0);
    // 5: misaligned target faults and stays faulted
    Advance = 1'b1; NextPC = 64'h42;
    @(negedge CLK);
    #1;
    chk("flt_fault", {63'd0, Fault}, 64'd1);
    chk("flt_pc", CurrentPC, 64'hFFFF_FFFF_FFFF_FFFC);
    for (int i = 0; i < 10; i++) begin
      Advance = i[0]; imem_ack = ~i[0]; NextPC = 64'h8; imem_rdata = 32'hCAFE0000;
      @(negedge CLK);
      #1;
      chk("flt_req", {63'd0, imem_req}, 64'd0);
      chk("flt_valid", {63'd0, InstValid}, 64'd0);
      chk("flt_sticky", {63'd0, Fault}, 64'd1);
    end
    Advance = 1'b0; imem_ack = 1'b0;
    Reset = 1'b1;
    @(negedge CLK);
    Reset = 1'b0;
    #1;
    chk("flt_clear", {63'd0, Fault}, 64'd0);
    fetch(0, 64'h0, 32'hAA000001, 1'b0);
`ifdef FETCH_PERF_EN
    // 6: counters over five retires with one stall cycle per fetch
    Reset = 1'b1;
    @(negedge CLK);
    Reset = 1'b0;
    for (int k = 0; k < 5; k++) begin
      fetch(1, 64'(k * 4), 32'(32'h10 + k), 1'b0);
      adv(64'((k + 1) * 4));
    end
    chk("retire_cnt", {32'd0, RetireCount}, 64'd5);
    chk("stall_cnt", {32'd0, StallCount}, 64'd5);
    Reset = 1'b1;
    @(negedge CLK);
    #1;
    chk("retire_rst", {32'd0, RetireCount}, 64'd0);
    chk("stall_rst", {32'd0, StallCount}, 64'd0);
    Reset = 1'b0;
`endif
    @(negedge CLK);
    chk("sb_drained", 64'(exp_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
